// File: rtl/led_mux_pkg.sv
// Shared types and constants for the four-digit seven-segment multiplexer.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package led_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz_blank;
    } disp_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry 15 is listed first so that HEX_SEG[n] is the pattern for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/led_mux_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
    import led_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/led_mux.sv
// Four-digit seven-segment scan multiplexer with anode guard time, blanking,
// leading-zero suppression and frame-aligned (tear-free) display updates.
module led_mux
    import led_pkg::*;
#(
    parameter int GUARD_CYCLES = 1000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame,
    output logic        pending
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1'b1);

    logic          r_scan_q;
    state_t        r_state;
    logic [1:0]    r_digit;
    logic [GW-1:0] r_guard_cnt;
    disp_t         r_disp;
    disp_t         r_pend;
    logic          r_pending;
    logic          r_frame;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp_n;

    logic          w_tick;
    logic          w_wrap;
    logic          w_commit;
    state_t        w_state_nx;
    logic [1:0]    w_digit_nx;
    logic [GW-1:0] w_guard_nx;
    disp_t         w_disp_nx;
    logic [3:0]    w_nib_zero;
    logic [3:0]    w_lz_dark;
    logic [3:0]    w_nibble;
    logic [6:0]    w_hex_seg;
    logic [3:0]    w_an_nx;
    logic [6:0]    w_seg_nx;
    logic          w_dp_n_nx;

    assign w_tick   = scan_clk & ~r_scan_q;
    assign w_wrap   = w_tick & (r_digit == 2'd3);
    assign w_commit = w_wrap & r_pending;

    // Edge detector register; resets high so a high scan_clk at release is not a tick.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_scan_q <= 1'b1;
        end else begin
            r_scan_q <= scan_clk;
        end
    end

    // FSM state register: state, current digit and guard countdown.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state     <= S_WAIT;
            r_digit     <= 2'd3;
            r_guard_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_digit     <= w_digit_nx;
            r_guard_cnt <= w_guard_nx;
        end
    end

    // FSM next state; a tick always wins and restarts the guard for the new digit.
    always_comb begin
        w_state_nx = r_state;
        w_digit_nx = r_digit;
        w_guard_nx = r_guard_cnt;
        if (w_tick) begin
            w_digit_nx = r_digit + 2'd1;
            if (GUARD_CYCLES > 0) begin
                w_state_nx = S_GUARD;
                w_guard_nx = GUARD_LOAD;
            end else begin
                w_state_nx = S_ON;
            end
        end else begin
            case (r_state)
                S_GUARD: begin
                    if (r_guard_cnt == '0) begin
                        w_state_nx = S_ON;
                    end else begin
                        w_guard_nx = r_guard_cnt - GUARD_ONE;
                    end
                end
                S_ON:    w_state_nx = S_ON;
                S_WAIT:  w_state_nx = S_WAIT;
                default: w_state_nx = S_WAIT;
            endcase
        end
    end

    // Display data only changes at the 3->0 wrap, and only if a load is waiting.
    always_comb begin
        if (w_commit) begin
            w_disp_nx = r_pend;
        end else begin
            w_disp_nx = r_disp;
        end
    end

    // Pending/display registers; a load coincident with a commit lands in pending.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_disp    <= '0;
            r_pend    <= '0;
            r_pending <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_disp    <= w_disp_nx;
            r_frame   <= w_wrap;
            r_pending <= load | (r_pending & ~w_commit);
            if (load) begin
                r_pend <= '{value: value, dp: dp, blank: blank, lz_blank: lz_blank};
            end else begin
                r_pend <= r_pend;
            end
        end
    end

    // A digit is a leading zero when it and all more-significant nibbles are zero.
    always_comb begin
        w_nib_zero[3] = (w_disp_nx.value[15:12] == 4'h0);
        w_nib_zero[2] = (w_disp_nx.value[11:8]  == 4'h0);
        w_nib_zero[1] = (w_disp_nx.value[7:4]   == 4'h0);
        w_nib_zero[0] = (w_disp_nx.value[3:0]   == 4'h0);
        if (w_disp_nx.lz_blank) begin
            w_lz_dark = {w_nib_zero[3], &w_nib_zero[3:2], &w_nib_zero[3:1], 1'b0};
        end else begin
            w_lz_dark = 4'b0000;
        end
    end

    assign w_nibble = w_disp_nx.value[{w_digit_nx, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_hex_seg)
    );

    // Output decode from next-state values so the registered outputs line up with the FSM.
    always_comb begin
        w_an_nx   = AN_OFF;
        w_seg_nx  = SEG_OFF;
        w_dp_n_nx = 1'b1;
        case (w_state_nx)
            S_ON: begin
                w_an_nx = ~(4'b0001 << w_digit_nx);
                if (w_disp_nx.blank[w_digit_nx]) begin
                    w_seg_nx  = SEG_OFF;
                    w_dp_n_nx = 1'b1;
                end else if (w_lz_dark[w_digit_nx]) begin
                    w_seg_nx  = SEG_OFF;
                    w_dp_n_nx = ~w_disp_nx.dp[w_digit_nx];
                end else begin
                    w_seg_nx  = w_hex_seg;
                    w_dp_n_nx = ~w_disp_nx.dp[w_digit_nx];
                end
            end
            S_WAIT, S_GUARD: begin
                w_an_nx   = AN_OFF;
                w_seg_nx  = SEG_OFF;
                w_dp_n_nx = 1'b1;
            end
            default: begin
                w_an_nx   = AN_OFF;
                w_seg_nx  = SEG_OFF;
                w_dp_n_nx = 1'b1;
            end
        endcase
    end

    // Registered display drive.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_an   <= AN_OFF;
            r_seg  <= SEG_OFF;
            r_dp_n <= 1'b1;
        end else begin
            r_an   <= w_an_nx;
            r_seg  <= w_seg_nx;
            r_dp_n <= w_dp_n_nx;
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp_n    = r_dp_n;
    assign frame   = r_frame;
    assign pending = r_pending;

endmodule
